// File: rtl/aes_mon_pkg.sv
// Shared types and constants for the AES Trojan comparator stage.
// Purely declarative; no latency or backpressure of its own.
package aes_mon_pkg;

  // Pipeline depth of the AES-128 cores feeding the monitor
  localparam int AES_LATENCY = 21;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/aes_mon_delay.sv
// Fixed-depth shift register with synchronous clear; latency DEPTH cycles.
// No backpressure: shifts every cycle.
module aes_mon_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/aes_trojan_monitor.sv
// Compares suspect vs golden AES outputs LATENCY cycles after each issue; counts tests/mismatches, captures first fail.
// Throttles issue via issue_ready; AES_MON_CAPTURE_EN adds the stimulus delay line and state/key capture.
module aes_trojan_monitor
  import aes_mon_pkg::*;
#(
  parameter int LATENCY   = AES_LATENCY,
  parameter int NUM_TESTS = 100,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              issue_ready,
  input  logic              in_valid,
  input  logic [127:0]      in_state,
  input  logic [127:0]      in_key,
  input  logic [127:0]      dut_out,
  input  logic [127:0]      gold_out,
  output logic              busy,
  output logic              done,
  output logic              detected,
  output logic [CNT_W-1:0]  test_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [127:0]      first_fail_state,
  output logic [127:0]      first_fail_key,
  output logic [127:0]      first_fail_dut,
  output logic [127:0]      first_fail_gold
);

  localparam logic [CNT_W-1:0] N_LIM  = CNT_W'(NUM_TESTS);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(NUM_TESTS - 1);

  mon_state_t       state;
  logic [CNT_W-1:0] issued;
  logic             run_start;
  logic             clr;
  logic             accept;
  logic             cmp_vld;
  logic             mismatch;
  logic             first_hit;
  block_t           ff_dut;
  block_t           ff_gold;

  assign run_start   = start && (state == ST_IDLE || state == ST_DONE);
  assign clr         = rst || run_start;
  assign issue_ready = (state == ST_RUN) && (issued < N_LIM);
  assign accept      = in_valid && issue_ready;
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign done        = (state == ST_DONE);

  aes_mon_delay #(.WIDTH(1), .DEPTH(LATENCY)) u_vld_pipe (
    .clk (clk),
    .clr (clr),
    .d   (accept),
    .q   (cmp_vld)
  );

  // Case inequality so X/Z on either core output is reported as a mismatch
  assign mismatch  = cmp_vld && (dut_out !== gold_out);
  assign first_hit = mismatch && !detected;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      issued         <= '0;
      test_count     <= '0;
      mismatch_count <= '0;
      detected       <= 1'b0;
      first_fail_idx <= '0;
      ff_dut         <= '0;
      ff_gold        <= '0;
    end else begin
      case (state)
        ST_RUN:   if (accept && issued == N_LAST) state <= ST_DRAIN;
        ST_DRAIN: if (cmp_vld && test_count == N_LAST) state <= ST_DONE;
        default:  if (start) state <= ST_RUN;
      endcase
      if (accept) issued <= issued + CNT_W'(1);
      if (cmp_vld) test_count <= test_count + CNT_W'(1);
      if (mismatch && mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
      if (first_hit) begin
        detected       <= 1'b1;
        first_fail_idx <= test_count;
        ff_dut         <= dut_out;
        ff_gold        <= gold_out;
      end
      if (run_start) begin
        issued         <= '0;
        test_count     <= '0;
        mismatch_count <= '0;
        detected       <= 1'b0;
        first_fail_idx <= '0;
        ff_dut         <= '0;
        ff_gold        <= '0;
      end
    end
  end

  assign first_fail_dut  = ff_dut;
  assign first_fail_gold = ff_gold;

`ifdef AES_MON_CAPTURE_EN
  logic [255:0] stim_q;
  block_t       ff_state;
  block_t       ff_key;

  aes_mon_delay #(.WIDTH(256), .DEPTH(LATENCY)) u_stim_pipe (
    .clk (clk),
    .clr (clr),
    .d   ({in_state, in_key}),
    .q   (stim_q)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      ff_state <= '0;
      ff_key   <= '0;
    end else if (first_hit) begin
      ff_state <= stim_q[255:128];
      ff_key   <= stim_q[127:0];
    end
  end

  assign first_fail_state = ff_state;
  assign first_fail_key   = ff_key;
`else
  logic unused_stim;
  assign unused_stim      = ^{in_state, in_key};
  assign first_fail_state = '0;
  assign first_fail_key   = '0;
`endif

endmodule

// File: tb/tb_aes_trojan_monitor.sv
// Directed bench: behavioural AES stand-in (out = state ^ key, LAT-cycle pipe) feeds both core inputs.
module tb_aes_trojan_monitor;

  localparam int LAT = 21;
  localparam int NT  = 100;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic [127:0] dut_out;
  logic [127:0] gold_out;
  logic         issue_ready, busy, done, detected;
  logic [15:0]  test_count, mismatch_count, first_fail_idx;
  logic [127:0] first_fail_state, first_fail_key, first_fail_dut, first_fail_gold;

  logic         s_start = 1'b0;
  logic         s_in_valid = 1'b0;
  logic [127:0] s_zero = '0;
  logic [127:0] s_dut = 128'h0;
  logic [127:0] s_gold = 128'h1;
  logic         s_issue_ready, s_busy, s_done, s_detected;
  logic [3:0]   s_test, s_mm, s_idx;
  logic [127:0] s_ff_state, s_ff_key, s_ff_dut, s_ff_gold;

  int n_vec = 0;
  int n_miscmp = 0;

  logic [127:0] stim_state [128];
  logic [127:0] stim_key [128];
  int cur_tag = -1;
  int fault_tag = -1;
  int x_tag = -1;

  logic [127:0] pipe_dat [LAT];
  int           pipe_tag [LAT];

  aes_trojan_monitor #(.LATENCY(LAT), .NUM_TESTS(NT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .issue_ready(issue_ready),
    .in_valid(in_valid), .in_state(in_state), .in_key(in_key),
    .dut_out(dut_out), .gold_out(gold_out), .busy(busy), .done(done),
    .detected(detected), .test_count(test_count), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx), .first_fail_state(first_fail_state),
    .first_fail_key(first_fail_key), .first_fail_dut(first_fail_dut),
    .first_fail_gold(first_fail_gold)
  );

  aes_trojan_monitor #(.LATENCY(3), .NUM_TESTS(15), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .issue_ready(s_issue_ready),
    .in_valid(s_in_valid), .in_state(s_zero), .in_key(s_zero),
    .dut_out(s_dut), .gold_out(s_gold), .busy(s_busy), .done(s_done),
    .detected(s_detected), .test_count(s_test), .mismatch_count(s_mm),
    .first_fail_idx(s_idx), .first_fail_state(s_ff_state),
    .first_fail_key(s_ff_key), .first_fail_dut(s_ff_dut),
    .first_fail_gold(s_ff_gold)
  );

  // Core stand-in: each issue is tagged with its test index so faults can be planted per test
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_dat[i] <= pipe_dat[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
    pipe_dat[0] <= in_state ^ in_key;
    pipe_tag[0] <= in_valid ? cur_tag : -1;
  end

  always_comb begin
    gold_out = pipe_dat[LAT-1];
    dut_out  = pipe_dat[LAT-1];
    if (fault_tag >= 0 && pipe_tag[LAT-1] == fault_tag) dut_out = pipe_dat[LAT-1] ^ 128'h1;
    if (x_tag >= 0 && pipe_tag[LAT-1] == x_tag) dut_out = 'x;
  end

  task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // hold=1: in_valid every cycle for ncyc cycles; hold=0: random gaps until nmax issued
  task automatic issue(input int ncyc, input bit hold, input int nmax, input bit chk_rdy);
    int k = 0;
    int cyc = 0;
    while ((hold && cyc < ncyc) || (!hold && k < nmax && cyc < 2000)) begin
      if (hold || $urandom_range(0, 3) != 0) begin
        if (chk_rdy && (k == NT - 1 || k == NT))
          chk_vec($sformatf("issue_ready_k%0d", k), issue_ready, (k < NT) ? 1 : 0);
        in_valid = 1'b1;
        in_state = stim_state[k];
        in_key   = stim_key[k];
        cur_tag  = k;
        k++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    cur_tag  = -1;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 400) begin
      tick();
      c++;
    end
    chk_vec(tag, done, 1);
  endtask

  task automatic chk_idle_zero(input string pfx);
    chk_vec({pfx, "_issue_ready"}, issue_ready, 0);
    chk_vec({pfx, "_busy"}, busy, 0);
    chk_vec({pfx, "_done"}, done, 0);
    chk_vec({pfx, "_detected"}, detected, 0);
    chk_vec({pfx, "_test_count"}, test_count, 0);
    chk_vec({pfx, "_mismatch_count"}, mismatch_count, 0);
    chk_vec({pfx, "_first_fail_idx"}, first_fail_idx, 0);
    chk_vec({pfx, "_first_fail_dut"}, first_fail_dut, 0);
    chk_vec({pfx, "_first_fail_gold"}, first_fail_gold, 0);
    chk_vec({pfx, "_first_fail_state"}, first_fail_state, 0);
  endtask

  initial begin
    logic [127:0] exp_state, exp_key;
    int c;
    for (int i = 0; i < 128; i++) begin
      stim_state[i] = {$urandom, $urandom, $urandom, $urandom};
      stim_key[i]   = {$urandom, $urandom, $urandom, $urandom};
    end
    stim_state[2] = 128'h0123456789abcdef_fedcba9876543210;
    stim_key[2]   = 128'h0;

    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Latency alignment: single stimulus at cycle 5 of the run
    do_start();
    chk_vec("run_busy", busy, 1);
    chk_vec("run_issue_ready", issue_ready, 1);
    repeat (5) tick();
    in_valid = 1'b1; in_state = stim_state[0]; in_key = stim_key[0]; cur_tag = 0;
    tick();
    in_valid = 1'b0; cur_tag = -1;
    repeat (20) tick();
    chk_vec("lat_cycle26", test_count, 0);
    tick();
    chk_vec("lat_cycle27", test_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("lat_rst");

    // All equal, random gaps
    do_start();
    issue(0, 1'b0, NT, 1'b0);
    wait_done("allеq_done");
    chk_vec("alleq_test_count", test_count, NT);
    chk_vec("alleq_mismatch", mismatch_count, 0);
    chk_vec("alleq_detected", detected, 0);
    chk_vec("alleq_busy", busy, 0);
    chk_vec("alleq_issue_ready", issue_ready, 0);

    // Single fault on test 37, back-to-back issue; done one cycle after the last compare
    fault_tag = 37;
    do_start();
    chk_vec("sf_cleared_count", test_count, 0);
    chk_vec("sf_cleared_done", done, 0);
    issue(NT, 1'b1, NT, 1'b0);
    repeat (20) tick();
    chk_vec("sf_cycle120_done", done, 0);
    chk_vec("sf_cycle120_count", test_count, NT - 1);
    tick();
    chk_vec("sf_cycle121_done", done, 1);
    chk_vec("sf_test_count", test_count, NT);
    chk_vec("sf_mismatch", mismatch_count, 1);
    chk_vec("sf_detected", detected, 1);
    chk_vec("sf_idx", first_fail_idx, 37);
    chk_vec("sf_dut_xor_gold", first_fail_dut ^ first_fail_gold, 128'h1);
    chk_vec("sf_gold", first_fail_gold, stim_state[37] ^ stim_key[37]);
`ifdef AES_MON_CAPTURE_EN
    exp_state = stim_state[37];
    exp_key   = stim_key[37];
`else
    exp_state = '0;
    exp_key   = '0;
`endif
    chk_vec("sf_state", first_fail_state, exp_state);
    chk_vec("sf_key", first_fail_key, exp_key);
    fault_tag = -1;

    // Over-issue for 120 cycles, X on test 2
    x_tag = 2;
    do_start();
    issue(120, 1'b1, NT, 1'b1);
    wait_done("ovr_done");
    chk_vec("ovr_test_count", test_count, NT);
    chk_vec("ovr_mismatch", mismatch_count, 1);
    chk_vec("ovr_idx", first_fail_idx, 2);
    chk_vec("ovr_gold", first_fail_gold, 128'h0123456789abcdef_fedcba9876543210);
    x_tag = -1;

    // Reset after 50 accepts with a fault on test 10 already seen
    fault_tag = 10;
    do_start();
    issue(50, 1'b1, NT, 1'b0);
    chk_vec("mid_pre_count", test_count, 29);
    chk_vec("mid_pre_detected", detected, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("mid_rst");
    fault_tag = -1;
    repeat (30) tick();
    chk_vec("mid_discard", test_count, 0);
    do_start();
    issue(0, 1'b0, NT, 1'b0);
    wait_done("clean_done");
    chk_vec("clean_test_count", test_count, NT);
    chk_vec("clean_mismatch", mismatch_count, 0);
    chk_vec("clean_detected", detected, 0);

    // Narrow counters: every compare mismatches
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_in_valid = 1'b1;
    repeat (20) tick();
    s_in_valid = 1'b0;
    c = 0;
    while (!s_done && c < 100) begin
      tick();
      c++;
    end
    chk_vec("sat_done", s_done, 1);
    chk_vec("sat_test_count", s_test, 4'hF);
    chk_vec("sat_mismatch", s_mm, 4'hF);
    chk_vec("sat_idx", s_idx, 4'h0);
    chk_vec("sat_detected", s_detected, 1);
    chk_vec("sat_ff_gold", s_ff_gold, 128'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/aes_trojan_monitor.md
# aes_trojan_monitor

- Hardware comparator stage directly downstream of the paired AES-128 cores (Trojan-suspect DUT and golden reference).
- Tracks each stimulus issued to both cores through a latency-matched pipeline, compares the two 128-bit ciphertexts when they emerge, and counts tests and mismatches.
- Captures full context of the first mismatch and reports a sticky detection flag, so the software bench only reads results.

## Interface
- `LATENCY`, 21: cycles from stimulus issue to valid `out` on both AES cores; ≥1.
- `NUM_TESTS`, 100: stimuli per run; ≥1.
- `CNT_W`, 16: counter width; 2^CNT_W > NUM_TESTS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run (pulse).
- `issue_ready` out 1: high when a new stimulus may be issued.
- `in_valid` in 1: state/key presented to both cores this cycle.
- `in_state` in 128: plaintext issued.
- `in_key` in 128: key issued.
- `dut_out` in 128: suspect core output.
- `gold_out` in 128: golden core output.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until next `start` or reset.
- `detected` out 1: sticky; ≥1 mismatch this run.
- `test_count` out CNT_W: compares performed.
- `mismatch_count` out CNT_W: mismatching compares, saturating.
- `first_fail_idx` out CNT_W: test index (0-based) of first mismatch.
- `first_fail_state`, `first_fail_key` out 128 each: stimulus of first mismatch.
- `first_fail_dut`, `first_fail_gold` out 128 each: outputs at first mismatch.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with `start`=1 → RUN. Clears all counters, `detected`, the first-fail registers, and the valid pipe.
- RUN: `issue_ready` = (issued < NUM_TESTS). An `in_valid` is accepted only when `issue_ready`=1; otherwise it is ignored.
- RUN → DRAIN when issued reaches NUM_TESTS.
- DRAIN → DONE when `test_count` reaches NUM_TESTS.
- `start` in RUN/DRAIN is ignored.
- Each accepted stimulus enters a LATENCY-deep valid shift register; state and key enter a parallel delay line.
- When the delayed valid is high, the block compares `dut_out` against `gold_out`:
  - `test_count` increments.
  - On inequality, `mismatch_count` increments, saturating at all-ones.
  - On the first mismatch only, `detected` sets and the four `first_fail_*` registers plus `first_fail_idx` load.
- Comparison is full 128-bit inequality. In simulation, any X/Z bit counts as a mismatch (case-inequality semantics).
- `busy` = RUN or DRAIN. `done` = DONE.

## Timing
- Reset values: state IDLE; `issue_ready`, `busy`, `done`, `detected` = 0; all counters and `first_fail_*` = 0; pipes cleared.
- Stimulus accepted at cycle t is compared against core outputs sampled at the edge ending cycle t+LATENCY.
- Counters and flags update at that same edge and are visible from cycle t+LATENCY+1.
- `issue_ready` falls the cycle after the NUM_TESTS-th accept.
- `done` rises the cycle after the final compare.
- Back-to-back `in_valid` every cycle is supported; throughput is 1 compare/cycle.
- Reset mid-run: everything returns to reset values at the next edge. In-flight stimuli are discarded and never compared.
- `start` coincident with `rst`: reset wins.

## Configuration
- `AES_MON_CAPTURE_EN` defined: the state/key delay line exists and `first_fail_state`/`first_fail_key` hold the captured stimulus.
- Not defined:
  - The delay line is omitted; only the 1-bit valid pipe remains.
  - `first_fail_state`/`first_fail_key` are tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package `aes_mon_pkg`:
  - FSM state enum.
  - 128-bit block typedef.
  - Default `LATENCY` constant matching the AES-128 core pipeline.
- Sub-module `aes_mon_delay`: parameterised width/depth shift register with synchronous clear. Used for the valid pipe and, when enabled, the state/key line.

## Test plan
- **All equal:** NUM_TESTS=100, golden model fed to both inputs, 100 random stimuli → `done`=1, `test_count`=100, `mismatch_count`=0, `detected`=0.
- **Single fault:** flip `dut_out` bit 0 only on test 37 → `mismatch_count`=1, `first_fail_idx`=37, `first_fail_dut` ^ `first_fail_gold` = 128'h1, `first_fail_state`/`first_fail_key` equal stimulus 37 (with `AES_MON_CAPTURE_EN`).
- **Latency alignment:** LATENCY=21, single stimulus at cycle 5 → `test_count`=1 visible at cycle 27 and not before.
- **Saturation/overflow:** CNT_W=4, NUM_TESTS=15, every compare mismatched → `mismatch_count`=4'hF, `first_fail_idx`=0.
- **Reset mid-run:** assert `rst` after 50 accepts → all outputs 0 next cycle. A new `start` then yields a clean 100-test run.
- **Over-issue / X input:** `in_valid` held high for 120 cycles → only 100 accepted. `dut_out`=X on test 2 → counted as mismatch.
